// File: rtl/piradip_sample_packer.sv
// piradip_sample_packer
//
// Serial-to-parallel sample packer. It takes one real sample per AXI4-Stream
// beat and packs NSAMPLES of them into one wide beat in the RFDC lane format.
// A partial word can be flushed on s_tlast, with m_tkeep marking the valid
// lanes. Input backpressure follows the output register: a new sample is
// taken only when the output register is empty or is being drained this cycle.
//
// Parameters:
//   SAMPLE_WIDTH   bits per sample (multiple of 8)
//   NSAMPLES       samples per output beat (>= 2)
//   LSB_FIRST      1: first sample lands in lane 0, 0: in lane NSAMPLES-1
//   FLUSH_ON_LAST  1: s_tlast emits a partial beat, 0: s_tlast is sticky and
//                  rides out on the next full beat
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_tdata/tvalid/     per-sample input stream
//   tready/tlast
//   m_tdata/tkeep/      packed output stream, registered
//   tvalid/tready/tlast
//   beat_count          output beats transferred (wraps)
//   partial_count       partial beats transferred (saturates)

module piradip_sample_packer #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int NSAMPLES      = 8,
    parameter int LSB_FIRST     = 1,
    parameter int FLUSH_ON_LAST = 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [SAMPLE_WIDTH-1:0]             s_tdata,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic                                s_tlast,
    output logic [SAMPLE_WIDTH*NSAMPLES-1:0]    m_tdata,
    output logic [SAMPLE_WIDTH*NSAMPLES/8-1:0]  m_tkeep,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic                                m_tlast,
    output logic [31:0]                         beat_count,
    output logic [15:0]                         partial_count
);

    localparam int DATA_W     = SAMPLE_WIDTH * NSAMPLES;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int LANE_BYTES = SAMPLE_WIDTH / 8;
    localparam int LANE_W     = $clog2(NSAMPLES);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NSAMPLES - 1);
    localparam logic [KEEP_W-1:0] KEEP_FULL = {KEEP_W{1'b1}};

    // Assembly state: one lane per sample, plus which lanes hold data.
    logic [NSAMPLES-1:0][SAMPLE_WIDTH-1:0] asm_q;
    logic [NSAMPLES-1:0][SAMPLE_WIDTH-1:0] asm_next;
    logic [NSAMPLES-1:0]                   mask_q;
    logic [NSAMPLES-1:0]                   mask_next;
    logic [LANE_W-1:0]                     lane_q;
    logic [LANE_W-1:0]                     phys_lane;
    logic                                  sticky_q;

    logic                                  accept;
    logic                                  complete;
    logic                                  xfer;
    logic [KEEP_W-1:0]                     keep_next;
    logic                                  last_next;

    // Handshakes. s_tready looks only at the output register and m_tready,
    // so the assembly simply freezes while a finished word is waiting.
    always_comb begin
        s_tready  = ~m_tvalid | m_tready;
        accept    = s_tvalid & s_tready;
        xfer      = m_tvalid & m_tready;
        phys_lane = (LSB_FIRST != 0) ? lane_q : (LAST_LANE - lane_q);
        complete  = accept &
                    ((lane_q == LAST_LANE) | (s_tlast & (FLUSH_ON_LAST != 0)));
        last_next = s_tlast | sticky_q;
    end

    // The word as it would look with the current sample merged in. Lanes not
    // yet written are still zero because the assembly clears on completion.
    always_comb begin
        asm_next             = asm_q;
        mask_next            = mask_q;
        asm_next[phys_lane]  = s_tdata;
        mask_next[phys_lane] = 1'b1;
    end

    // Expand the lane mask into byte enables.
    always_comb begin
        keep_next = '0;
        for (int i = 0; i < NSAMPLES; i++) begin
            keep_next[i*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{mask_next[i]}};
        end
    end

    // Assembly register. A sticky tlast can only arise when tlast does not
    // complete the word, which never happens with flush-on-last enabled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            asm_q    <= '0;
            mask_q   <= '0;
            lane_q   <= '0;
            sticky_q <= 1'b0;
        end else if (accept) begin
            if (complete) begin
                asm_q    <= '0;
                mask_q   <= '0;
                lane_q   <= '0;
                sticky_q <= 1'b0;
            end else begin
                asm_q  <= asm_next;
                mask_q <= mask_next;
                lane_q <= lane_q + LANE_W'(1);
                if (s_tlast) begin
                    sticky_q <= 1'b1;
                end
            end
        end
    end

    // Output register. A completion in the same cycle as a transfer reloads
    // it directly, so back-to-back words need no bubble.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (complete) begin
            m_tdata  <= asm_next;
            m_tkeep  <= keep_next;
            m_tlast  <= last_next;
            m_tvalid <= 1'b1;
        end else if (xfer) begin
            m_tvalid <= 1'b0;
        end
    end

    // Transfer statistics. A beat is partial when any byte enable is clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count    <= '0;
            partial_count <= '0;
        end else if (xfer) begin
            beat_count <= beat_count + 32'd1;
            if ((m_tkeep != KEEP_FULL) && (partial_count != 16'hFFFF)) begin
                partial_count <= partial_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_piradip_sample_packer.sv
// tb_piradip_sample_packer
//
// Bench for piradip_sample_packer. Three instances share the clock and reset:
//   0: LSB_FIRST=1, FLUSH_ON_LAST=1 (default configuration)
//   1: LSB_FIRST=0, FLUSH_ON_LAST=1
//   2: LSB_FIRST=1, FLUSH_ON_LAST=0
// A per-instance reference model pushes expected beats into a queue when
// samples are accepted; the monitor pops and compares them on transfers.

module tb_piradip_sample_packer;

    localparam int SW = 16;
    localparam int NS = 8;
    localparam int DW = SW * NS;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [SW-1:0] s_tdata  [3];
    logic          s_tvalid [3];
    logic          s_tlast  [3];
    logic          m_tready [3];
    wire           s_tready [3];
    wire  [DW-1:0] m_tdata  [3];
    wire  [KW-1:0] m_tkeep  [3];
    wire           m_tvalid [3];
    wire           m_tlast  [3];
    wire  [31:0]   beat_count    [3];
    wire  [15:0]   partial_count [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rand_ready = 1'b0;

    // Reference model state
    logic [DW-1:0] mdl_word   [3];
    logic [KW-1:0] mdl_keep   [3];
    int            mdl_lane   [3];
    bit            mdl_sticky [3];
    int            exp_beats  [3];
    int            exp_partial[3];
    int            pops       [3];
    beat_t         q0[$];
    beat_t         q1[$];
    beat_t         q2[$];

    // DUT-side history of transferred beats, for the directed checks
    logic [DW-1:0] hist_data [3][16];
    logic [KW-1:0] hist_keep [3][16];
    logic          hist_last [3][16];
    int            hist_cyc  [3][16];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        piradip_sample_packer #(
            .SAMPLE_WIDTH (SW),
            .NSAMPLES     (NS),
            .LSB_FIRST    ((gi == 1) ? 0 : 1),
            .FLUSH_ON_LAST((gi == 2) ? 0 : 1)
        ) dut (
            .aclk         (aclk),
            .aresetn      (aresetn),
            .s_tdata      (s_tdata[gi]),
            .s_tvalid     (s_tvalid[gi]),
            .s_tready     (s_tready[gi]),
            .s_tlast      (s_tlast[gi]),
            .m_tdata      (m_tdata[gi]),
            .m_tkeep      (m_tkeep[gi]),
            .m_tvalid     (m_tvalid[gi]),
            .m_tready     (m_tready[gi]),
            .m_tlast      (m_tlast[gi]),
            .beat_count   (beat_count[gi]),
            .partial_count(partial_count[gi])
        );
    end

    initial forever #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Random output backpressure for instance 0
    initial forever begin
        @(posedge aclk);
        #1;
        if (rand_ready) m_tready[0] = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                               input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit lsbOf(input int i);
        return (i != 1);
    endfunction

    function automatic bit flushOf(input int i);
        return (i != 2);
    endfunction

    function automatic int qSize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qFront(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qPop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qPush(input int i, input beat_t b);
        case (i)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic qClear(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic modelClear(input int i);
        mdl_word[i]   = '0;
        mdl_keep[i]   = '0;
        mdl_lane[i]   = 0;
        mdl_sticky[i] = 1'b0;
    endtask

    // Runs at the falling edge: everything seen here is what the next rising
    // edge will act on.
    task automatic monitorStep(input int i);
        beat_t f;
        beat_t b;
        bit    ev;
        bit    er;
        int    p;
        if (!aresetn) begin
            modelClear(i);
            qClear(i);
            exp_beats[i]   = 0;
            exp_partial[i] = 0;
            return;
        end
        ev = (qSize(i) != 0);
        er = !ev || m_tready[i];
        checkOutput($sformatf("d%0d_m_tvalid", i), m_tvalid[i], ev);
        checkOutput($sformatf("d%0d_s_tready", i), s_tready[i], er);
        if (ev) begin
            f = qFront(i);
            checkOutput($sformatf("d%0d_m_tdata", i), m_tdata[i], f.data);
            checkOutput($sformatf("d%0d_m_tkeep", i), m_tkeep[i], f.keep);
            checkOutput($sformatf("d%0d_m_tlast", i), m_tlast[i], f.last);
            if (m_tready[i]) begin
                checkOutput($sformatf("d%0d_beat_count", i), beat_count[i], exp_beats[i]);
                checkOutput($sformatf("d%0d_partial_count", i), partial_count[i], exp_partial[i]);
                if (pops[i] < 16) begin
                    hist_data[i][pops[i]] = m_tdata[i];
                    hist_keep[i][pops[i]] = m_tkeep[i];
                    hist_last[i][pops[i]] = m_tlast[i];
                    hist_cyc[i][pops[i]]  = cyc;
                end
                pops[i]++;
                qPop(i);
                exp_beats[i]++;
                if (f.keep != {KW{1'b1}} && exp_partial[i] != 16'hFFFF) exp_partial[i]++;
            end
        end
        if (s_tvalid[i] && er) begin
            p = lsbOf(i) ? mdl_lane[i] : (NS - 1 - mdl_lane[i]);
            mdl_word[i][p*SW +: SW] = s_tdata[i];
            mdl_keep[i][p*2 +: 2]   = 2'b11;
            if (mdl_lane[i] == NS - 1 || (s_tlast[i] && flushOf(i))) begin
                b.data = mdl_word[i];
                b.keep = mdl_keep[i];
                b.last = s_tlast[i] | mdl_sticky[i];
                qPush(i, b);
                modelClear(i);
            end else begin
                mdl_lane[i]++;
                if (s_tlast[i]) mdl_sticky[i] = 1'b1;
            end
        end
    endtask

    always @(negedge aclk) begin
        for (int i = 0; i < 3; i++) monitorStep(i);
    end

    // Present one sample and hold it until the DUT takes it. Leaves s_tvalid
    // high so consecutive calls stream one sample per cycle.
    task automatic applyStimulus(input int i, input logic [SW-1:0] d, input logic last);
        bit acc;
        acc         = 1'b0;
        s_tdata[i]  = d;
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = last;
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge aclk);
            acc = s_tready[i];
            @(posedge aclk);
            #1;
        end
        if (!acc) checkOutput($sformatf("d%0d_accept_timeout", i), acc, 1'b1);
    endtask

    task automatic idle(input int i);
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    task automatic waitPops(input int i, input int n);
        for (int t = 0; t < 500 && pops[i] < n; t++) begin
            @(posedge aclk);
            #2;
        end
        checkOutput($sformatf("d%0d_beats_seen", i), pops[i], n);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            m_tready[i] = 1'b1;
            pops[i]     = 0;
            exp_beats[i]   = 0;
            exp_partial[i] = 0;
            modelClear(i);
        end

        // Reset values, while reset is held and after release
        aresetn = 1'b0;
        repeat (4) @(negedge aclk);
        checkOutput("rst_m_tvalid", m_tvalid[0], 1'b0);
        checkOutput("rst_m_tdata", m_tdata[0], '0);
        checkOutput("rst_m_tkeep", m_tkeep[0], '0);
        checkOutput("rst_m_tlast", m_tlast[0], 1'b0);
        checkOutput("rst_s_tready", s_tready[0], 1'b1);
        checkOutput("rst_beat_count", beat_count[0], 32'd0);
        checkOutput("rst_partial_count", partial_count[0], 16'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("rel_s_tready", s_tready[0], 1'b1);
        checkOutput("rel_m_tvalid", m_tvalid[0], 1'b0);
        @(posedge aclk);
        #1;

        // Full packing, continuous stream 1..16
        for (int k = 1; k <= 16; k++) applyStimulus(0, 16'(k), 1'b0);
        idle(0);
        waitPops(0, 2);
        checkOutput("full_b1_data", hist_data[0][0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        checkOutput("full_b1_keep", hist_keep[0][0], 16'hFFFF);
        checkOutput("full_b2_data", hist_data[0][1], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        checkOutput("full_b2_spacing", hist_cyc[0][1] - hist_cyc[0][0], 8);
        checkOutput("full_beat_count", beat_count[0], 32'd2);

        // Flush on tlast after three samples
        applyStimulus(0, 16'h000A, 1'b0);
        applyStimulus(0, 16'h000B, 1'b0);
        applyStimulus(0, 16'h000C, 1'b1);
        idle(0);
        waitPops(0, 3);
        checkOutput("flush_data", hist_data[0][2], 128'h000C_000B_000A);
        checkOutput("flush_keep", hist_keep[0][2], 16'h003F);
        checkOutput("flush_last", hist_last[0][2], 1'b1);
        checkOutput("flush_partial_count", partial_count[0], 16'd1);

        // tlast on lane 0 gives a single-lane beat
        applyStimulus(0, 16'h0055, 1'b1);
        idle(0);
        waitPops(0, 4);
        checkOutput("lane0_data", hist_data[0][3], 128'h0055);
        checkOutput("lane0_keep", hist_keep[0][3], 16'h0003);
        checkOutput("lane0_last", hist_last[0][3], 1'b1);
        checkOutput("lane0_partial_count", partial_count[0], 16'd2);

        // Backpressure: a finished word blocks further input
        m_tready[0] = 1'b0;
        for (int k = 'h101; k <= 'h108; k++) applyStimulus(0, 16'(k), 1'b0);
        fork
            begin
                for (int k = 'h109; k <= 'h110; k++) applyStimulus(0, 16'(k), 1'b0);
                idle(0);
            end
            begin
                repeat (4) @(negedge aclk);
                checkOutput("bp_s_tready", s_tready[0], 1'b0);
                checkOutput("bp_hold_data", m_tdata[0], 128'h0108_0107_0106_0105_0104_0103_0102_0101);
                checkOutput("bp_hold_valid", m_tvalid[0], 1'b1);
                @(posedge aclk);
                #1;
                m_tready[0] = 1'b1;
            end
        join
        waitPops(0, 6);
        checkOutput("bp_b1_data", hist_data[0][4], 128'h0108_0107_0106_0105_0104_0103_0102_0101);
        checkOutput("bp_b2_data", hist_data[0][5], 128'h0110_010F_010E_010D_010C_010B_010A_0109);

        // Random stalls, gaps and tlasts against the scoreboard
        rand_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(0);
                @(posedge aclk);
                #1;
            end
            applyStimulus(0, 16'($urandom), 1'($urandom_range(0, 9) == 0));
        end
        idle(0);
        rand_ready = 1'b0;
        @(posedge aclk);
        #3;
        m_tready[0] = 1'b1;
        for (int t = 0; t < 100 && qSize(0) != 0; t++) @(posedge aclk);
        checkOutput("rand_drained", qSize(0), 0);

        // MSB-first lane order
        for (int k = 1; k <= 8; k++) applyStimulus(1, 16'(k), 1'b0);
        idle(1);
        waitPops(1, 1);
        checkOutput("msb_data", hist_data[1][0], 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        checkOutput("msb_keep", hist_keep[1][0], 16'hFFFF);

        // No flush: tlast on sample 3 rides out on the full beat
        for (int k = 1; k <= 8; k++) applyStimulus(2, 16'(k), 1'(k == 3));
        idle(2);
        waitPops(2, 1);
        checkOutput("noflush_data", hist_data[2][0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        checkOutput("noflush_keep", hist_keep[2][0], 16'hFFFF);
        checkOutput("noflush_last", hist_last[2][0], 1'b1);
        checkOutput("noflush_partial_count", partial_count[2], 16'd0);

        // Reset in the middle of a packet discards the partial word
        for (int k = 'h11; k <= 'h15; k++) applyStimulus(2, 16'(k), 1'b0);
        idle(2);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checkOutput("midrst_m_tvalid", m_tvalid[2], 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("midrst_beat_count", beat_count[2], 32'd0);
        @(posedge aclk);
        #1;
        for (int k = 'h21; k <= 'h28; k++) applyStimulus(2, 16'(k), 1'b0);
        idle(2);
        waitPops(2, 2);
        checkOutput("midrst_data", hist_data[2][1], 128'h0028_0027_0026_0025_0024_0023_0022_0021);
        checkOutput("midrst_keep", hist_keep[2][1], 16'hFFFF);
        checkOutput("midrst_last", hist_last[2][1], 1'b0);

        repeat (5) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piradip_sample_packer.md
# piradip_sample_packer

Synthesizable, parametrised serial-to-parallel sample packer. It accepts one real sample per AXI4-Stream beat and packs NSAMPLES samples into one wide beat in the format the RFDC DAC/ADC lanes use. A partial word on TLAST can be flushed with TKEEP marking the valid lanes. It sits between per-sample DSP or test-pattern sources and the wide RFDC-facing stream, and replaces the behavioural shift-register packing in the bench models with real handshaking and backpressure.

## Interface
Parameters:
- SAMPLE_WIDTH, 16: bits per sample; must be a multiple of 8.
- NSAMPLES, 8: samples per output beat; must be ≥ 2.
- LSB_FIRST, 1: 1 places the first sample in lane 0 (bits [SAMPLE_WIDTH-1:0]); 0 places it in lane NSAMPLES-1.
- FLUSH_ON_LAST, 1: 1 emits a partial beat when s_tlast is accepted; 0 treats s_tlast as ordinary data (no flush) and forwards it only on a full beat.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_tdata  in  SAMPLE_WIDTH  input sample (two's complement, passed unmodified).
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  end of packet.
- m_tdata  out  SAMPLE_WIDTH*NSAMPLES  packed output.
- m_tkeep  out  SAMPLE_WIDTH*NSAMPLES/8  byte enables; all ones on full beats.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  set on the beat containing the accepted s_tlast sample.
- beat_count  out  32  output beats transferred; wraps modulo 2^32.
- partial_count  out  16  partial (flushed) beats transferred; saturates at 16'hFFFF.

## Operation
- Internal state:
  - assembly register, NSAMPLES lanes;
  - lane index `lane`, 0..NSAMPLES-1;
  - lane-valid mask;
  - output register holding m_tdata, m_tkeep, m_tlast and m_tvalid.
- Accept (input handshake) = s_tvalid & s_tready.
- s_tready = ~m_tvalid | m_tready. This is combinational from m_tready and depends on no input signal.
- On accept, the sample is written to physical lane p, where p = lane if LSB_FIRST = 1, else NSAMPLES-1-lane.
- Completion condition, evaluated on accept: lane == NSAMPLES-1, or (s_tlast & FLUSH_ON_LAST).
- On completion, the output register loads:
  - m_tdata: the assembled word including the current sample; unfilled lanes are 0.
  - m_tkeep: the filled lanes, SAMPLE_WIDTH/8 bits per lane.
  - m_tlast: s_tlast.
  - m_tvalid: 1.
- After completion, lane and the mask clear to 0.
- On an accept that does not complete a word, lane increments by 1.
- With FLUSH_ON_LAST = 0, a tlast on a non-final lane is held in a sticky flag. m_tlast is set on the completing beat if the flag or the current s_tlast is set, and the flag then clears.
- Output transfer = m_tvalid & m_tready. On a transfer with no new completion in the same cycle, m_tvalid drops to 0.
- Simultaneous output transfer and new completion: the output register reloads and m_tvalid stays 1. This gives full throughput with no bubble.
- Counters:
  - beat_count increments on every output transfer.
  - partial_count increments on transfers where m_tkeep is not all ones, saturating at 16'hFFFF.
- Reset mid-packet discards any partial assembly. No flush is emitted.

## Timing
- Reset (async assert, release synchronous to aclk) forces these values:
  - m_tvalid = 0, m_tdata = 0, m_tkeep = 0, m_tlast = 0;
  - lane = 0, lane-valid mask = 0, sticky tlast flag = 0;
  - beat_count = 0, partial_count = 0.
- s_tready is 1 during reset.
- Latency: a sample accepted at edge N that completes a word appears with m_tvalid = 1 after edge N (visible in cycle N+1).
- Throughput: one sample per cycle sustained with m_tready held at 1.
- While m_tvalid = 1 and m_tready = 0:
  - m_tdata, m_tkeep and m_tlast hold stable (AXI rule);
  - s_tready = 0;
  - the assembly stalls, even if lanes remain free.
- m_tvalid never deasserts without a transfer.
- tlast on lane 0 with FLUSH_ON_LAST = 1 produces a single-lane beat: m_tkeep = lane 0 bytes only (LSB_FIRST = 1).

## Test plan
- Reset check, SAMPLE_WIDTH = 16, NSAMPLES = 8, LSB_FIRST = 1, m_tready = 1: hold aresetn low, then release. Required: all outputs at their reset values and s_tready = 1.
- Full packing, same configuration, m_tready = 1: stream 0x0001..0x0010 continuously.
  - Beat 1: m_tdata = 0x0008_0007_0006_0005_0004_0003_0002_0001, m_tkeep = 16'hFFFF.
  - Beat 2 follows exactly 8 cycles later; beat_count = 2.
- Flush: send 0x0A, 0x0B, 0x0C with tlast on 0x0C. Required: m_tdata = 0x…000C_000B_000A (upper lanes 0), m_tkeep = 16'h003F, m_tlast = 1, partial_count = 1.
- Backpressure: hold m_tready = 0 after the first full beat. Required: s_tready = 0 on the cycle the next word completes; m_tdata stays stable; no samples are lost or duplicated across 100 random stall patterns, checked against a scoreboard.
- LSB_FIRST = 0: send 1..8. Required: m_tdata = 0x0001_0002_0003_0004_0005_0006_0007_0008.
- FLUSH_ON_LAST = 0, plus reset mid-packet:
  - Send tlast on sample 3 of 8. Required: no flush; m_tlast = 1 on the full beat at sample 8.
  - Assert aresetn low after 5 samples. Required: no output beat, and the next 8 samples form a clean beat starting at lane 0.
